// File: rtl/fetch_frontend_if.sv
// Bundle of the fetch front end's memory, decode and control signals.
// The master modport is the fetch front end; the slave side is memory, decode and control.
interface fetch_frontend_if #(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 14,
    parameter int DEPTH   = 4
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic               o_imem_req;
    logic [PC_W-1:0]    o_imem_addr;
    logic [INSTR_W-1:0] i_imem_data;
    logic               o_dec_valid;
    logic [INSTR_W-1:0] o_dec_instr;
    logic [PC_W-1:0]    o_dec_pc;
    logic               i_dec_ready;
    logic               i_redirect;
    logic [PC_W-1:0]    i_redirect_pc;
    logic               i_halt;
    logic               o_halted;
    logic [OCC_W-1:0]   o_occupancy;

    modport master (
        output o_imem_req, o_imem_addr, o_dec_valid, o_dec_instr, o_dec_pc,
               o_halted, o_occupancy,
        input  i_imem_data, i_dec_ready, i_redirect, i_redirect_pc, i_halt
    );

    modport slave (
        input  o_imem_req, o_imem_addr, o_dec_valid, o_dec_instr, o_dec_pc,
               o_halted, o_occupancy,
        output i_imem_data, i_dec_ready, i_redirect, i_redirect_pc, i_halt
    );
endinterface

// File: rtl/fetch_frontend.sv
// Instruction fetch front end: PC generator, one-cycle imem request port and a
// DEPTH-entry prefetch FIFO feeding decode, with redirect flush and sticky halt.
module fetch_frontend #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 14,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input logic              clk,
    input logic              reset,
    fetch_frontend_if.master fe
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]   DEPTH_CR = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_CN = CNT_W'(DEPTH);

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return ptr + PTR_W'(1);
    endfunction

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [PC_W-1:0]    pc_req_q;
    logic               inflight_q, inflight_d;
    logic               halted_q, halted_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [PC_W-1:0]    pc_mem_q    [DEPTH];

    logic             dec_valid;
    logic             pop;
    logic             push;
    logic             req;
    logic [CNT_W:0]   credit;

    // The credit counts the in-flight fetch as occupied, so a push never finds the FIFO full.
    always_comb begin
        dec_valid = (count_q != '0);
        pop       = dec_valid & fe.i_dec_ready;
        push      = inflight_q & ~fe.i_redirect;
        credit    = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
        req       = ~halted_q & ~fe.i_redirect & (credit < DEPTH_CR);
    end

    always_comb begin
        pc_d       = pc_q;
        inflight_d = req;
        halted_d   = halted_q | fe.i_halt;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (fe.i_redirect) begin
            pc_d       = fe.i_redirect_pc;
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (req) begin
                pc_d = pc_inc(pc_q);
            end
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            halted_q   <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            halted_q   <= halted_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Data path carries no reset: push is gated by inflight_q, which reset clears.
    always_ff @(posedge clk) begin
        if (req) begin
            pc_req_q <= pc_q;
        end
        if (push) begin
            instr_mem_q[wr_ptr_q] <= fe.i_imem_data;
            pc_mem_q[wr_ptr_q]    <= pc_req_q;
        end
    end

    assign fe.o_imem_req  = req;
    assign fe.o_imem_addr = pc_q;
    assign fe.o_dec_valid = dec_valid;
    assign fe.o_dec_instr = dec_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign fe.o_dec_pc    = dec_valid ? pc_mem_q[rd_ptr_q]    : '0;
    assign fe.o_halted    = halted_q;
    assign fe.o_occupancy = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push && !pop && count_q == DEPTH_CN));
endmodule

// File: tb/tb_fetch_frontend.sv
// Directed bench for fetch_frontend: vector table for the start-up stream plus
// hand-written sequences for stall, redirect, halt, wrap and reset corner cases.
module tb_fetch_frontend;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_frontend_if #(.PC_W(8), .INSTR_W(14), .DEPTH(4)) ifa ();
    fetch_frontend_if #(.PC_W(4), .INSTR_W(14), .DEPTH(4)) ifb ();

    fetch_frontend #(.PC_W(8), .INSTR_W(14), .DEPTH(4), .RESET_PC(8'd0)) dut_a (
        .clk(clk), .reset(reset), .fe(ifa)
    );
    fetch_frontend #(.PC_W(4), .INSTR_W(14), .DEPTH(4), .RESET_PC(4'd14)) dut_b (
        .clk(clk), .reset(reset), .fe(ifb)
    );

    // Instruction memory model: imem[a] = a + 0x100, one cycle after the request.
    always @(posedge clk) begin
        if (ifa.o_imem_req) ifa.i_imem_data <= {6'b0, ifa.o_imem_addr} + 14'h100;
        if (ifb.o_imem_req) ifb.i_imem_data <= {10'b0, ifb.o_imem_addr} + 14'h100;
    end

    assign ifb.i_dec_ready   = 1'b1;
    assign ifb.i_redirect    = 1'b0;
    assign ifb.i_redirect_pc = 4'd0;
    assign ifb.i_halt        = 1'b0;

    logic       b_rec = 1'b0;
    logic [3:0] b_pcs [$];
    logic [13:0] b_ins [$];
    always @(negedge clk) begin
        if (b_rec && !reset && ifb.o_dec_valid) begin
            b_pcs.push_back(ifb.o_dec_pc);
            b_ins.push_back(ifb.o_dec_instr);
        end
    end

    typedef struct {
        bit ready; bit redirect; bit halt;
        int req; int addr; int valid; int pc; int instr; int occ;
    } vec_t;
    vec_t tv [8];

    logic [7:0] got [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic sample_deliv();
        if (ifa.o_dec_valid && ifa.i_dec_ready) begin
            got.push_back(ifa.o_dec_pc);
            chk("deliv_instr", int'(ifa.o_dec_instr), int'({6'b0, ifa.o_dec_pc}) + 'h100);
        end
    endtask

    // Asserted between edges so the reset-state checks prove the reset is asynchronous.
    task automatic do_reset(input logic rdy);
        reset = 1'b1;
        ifa.i_redirect = 1'b0;
        ifa.i_redirect_pc = 8'd0;
        ifa.i_halt = 1'b0;
        ifa.i_dec_ready = rdy;
        #1;
        chk("rst_valid", int'(ifa.o_dec_valid), 0);
        chk("rst_occ", int'(ifa.o_occupancy), 0);
        chk("rst_halted", int'(ifa.o_halted), 0);
        chk("rst_dec_pc", int'(ifa.o_dec_pc), 0);
        chk("rst_dec_instr", int'(ifa.o_dec_instr), 0);
        chk("rst_addr", int'(ifa.o_imem_addr), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tv[0] = '{1, 0, 0, 1, 'h00, 0, 'h00, 'h000, 0};
        tv[1] = '{1, 0, 0, 1, 'h01, 0, 'h00, 'h000, 0};
        tv[2] = '{1, 0, 0, 1, 'h02, 1, 'h00, 'h100, 1};
        tv[3] = '{1, 0, 0, 1, 'h03, 1, 'h01, 'h101, 1};
        tv[4] = '{1, 0, 0, 1, 'h04, 1, 'h02, 'h102, 1};
        tv[5] = '{1, 0, 0, 1, 'h05, 1, 'h03, 'h103, 1};
        tv[6] = '{1, 0, 0, 1, 'h06, 1, 'h04, 'h104, 1};
        tv[7] = '{1, 0, 0, 1, 'h07, 1, 'h05, 'h105, 1};

        ifa.i_dec_ready = 1'b0;
        ifa.i_redirect = 1'b0;
        ifa.i_redirect_pc = 8'd0;
        ifa.i_halt = 1'b0;
        #2;

        // Start-up stream, with the PC_W=4 instance running alongside from RESET_PC=14.
        b_rec = 1'b1;
        do_reset(1'b1);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            ifa.i_dec_ready = tv[i].ready;
            ifa.i_redirect = tv[i].redirect;
            ifa.i_halt = tv[i].halt;
            #1;
            chk($sformatf("t1_req[%0d]", i), int'(ifa.o_imem_req), tv[i].req);
            chk($sformatf("t1_addr[%0d]", i), int'(ifa.o_imem_addr), tv[i].addr);
            chk($sformatf("t1_valid[%0d]", i), int'(ifa.o_dec_valid), tv[i].valid);
            chk($sformatf("t1_pc[%0d]", i), int'(ifa.o_dec_pc), tv[i].pc);
            chk($sformatf("t1_instr[%0d]", i), int'(ifa.o_dec_instr), tv[i].instr);
            chk($sformatf("t1_occ[%0d]", i), int'(ifa.o_occupancy), tv[i].occ);
        end
        b_rec = 1'b0;
        chk("t5_count", (b_pcs.size() >= 4) ? 1 : 0, 1);
        if (b_pcs.size() >= 4) begin
            chk("t5_pc0", int'(b_pcs[0]), 14);
            chk("t5_pc1", int'(b_pcs[1]), 15);
            chk("t5_pc2", int'(b_pcs[2]), 0);
            chk("t5_pc3", int'(b_pcs[3]), 1);
            chk("t5_instr2", int'(b_ins[2]), 'h100);
        end

        // Decode stalled: FIFO fills to DEPTH, then drains in order without loss.
        do_reset(1'b0);
        #1;
        chk("t2_occ_c1", int'(ifa.o_occupancy), 0);
        step();
        chk("t2_occ_c2", int'(ifa.o_occupancy), 0);
        repeat (8) step();
        chk("t2_occ_full", int'(ifa.o_occupancy), 4);
        chk("t2_req_full", int'(ifa.o_imem_req), 0);
        chk("t2_addr_full", int'(ifa.o_imem_addr), 4);
        ifa.i_dec_ready = 1'b1;
        #1;
        chk("t2_req_resume", int'(ifa.o_imem_req), 1);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t2_valid[%0d]", i), int'(ifa.o_dec_valid), 1);
            chk($sformatf("t2_pc[%0d]", i), int'(ifa.o_dec_pc), i);
            chk($sformatf("t2_instr[%0d]", i), int'(ifa.o_dec_instr), i + 'h100);
            step();
        end

        // Redirect with pcs 5..7 queued and pc 8 in flight.
        do_reset(1'b0);
        #1;
        repeat (5) step();
        chk("t3_full", int'(ifa.o_occupancy), 4);
        ifa.i_redirect = 1'b1;
        ifa.i_redirect_pc = 8'h05;
        #1;
        chk("t3_req_redir", int'(ifa.o_imem_req), 0);
        step();
        ifa.i_redirect = 1'b0;
        #1;
        chk("t3_occ_a", int'(ifa.o_occupancy), 0);
        chk("t3_addr_a", int'(ifa.o_imem_addr), 5);
        chk("t3_req_a", int'(ifa.o_imem_req), 1);
        repeat (3) step();
        chk("t3_addr_d", int'(ifa.o_imem_addr), 8);
        chk("t3_req_d", int'(ifa.o_imem_req), 1);
        step();
        chk("t3_occ_e", int'(ifa.o_occupancy), 3);
        chk("t3_req_e", int'(ifa.o_imem_req), 0);
        chk("t3_head_e", int'(ifa.o_dec_pc), 5);
        ifa.i_redirect = 1'b1;
        ifa.i_redirect_pc = 8'h40;
        #1;
        chk("t3_req_redir2", int'(ifa.o_imem_req), 0);
        step();
        ifa.i_redirect = 1'b0;
        ifa.i_dec_ready = 1'b1;
        #1;
        chk("t3_occ_flush", int'(ifa.o_occupancy), 0);
        chk("t3_valid_flush", int'(ifa.o_dec_valid), 0);
        chk("t3_addr_new", int'(ifa.o_imem_addr), 'h40);
        chk("t3_req_new", int'(ifa.o_imem_req), 1);
        got.delete();
        for (int i = 0; i < 8; i++) begin
            sample_deliv();
            step();
        end
        chk("t3_ndeliv", got.size(), 6);
        foreach (got[k]) chk($sformatf("t3_pc[%0d]", k), int'(got[k]), 'h40 + k);

        // Halt with two entries queued and one fetch in flight.
        do_reset(1'b0);
        #1;
        ifa.i_redirect = 1'b1;
        ifa.i_redirect_pc = 8'h07;
        #1;
        step();
        ifa.i_redirect = 1'b0;
        #1;
        chk("t4_addr7", int'(ifa.o_imem_addr), 7);
        chk("t4_req7", int'(ifa.o_imem_req), 1);
        repeat (2) step();
        chk("t4_addr9", int'(ifa.o_imem_addr), 9);
        ifa.i_halt = 1'b1;
        #1;
        chk("t4_req_halt_cycle", int'(ifa.o_imem_req), 1);
        step();
        ifa.i_halt = 1'b0;
        #1;
        chk("t4_req_after", int'(ifa.o_imem_req), 0);
        chk("t4_halted", int'(ifa.o_halted), 1);
        chk("t4_occ", int'(ifa.o_occupancy), 2);
        ifa.i_dec_ready = 1'b1;
        #1;
        got.delete();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_req_off[%0d]", i), int'(ifa.o_imem_req), 0);
            sample_deliv();
            step();
        end
        chk("t4_ndeliv", got.size(), 3);
        foreach (got[k]) chk($sformatf("t4_pc[%0d]", k), int'(got[k]), 7 + k);
        chk("t4_halted_sticky", int'(ifa.o_halted), 1);

        // Redirect and halt together.
        do_reset(1'b1);
        #1;
        repeat (3) step();
        chk("t6_busy", int'(ifa.o_occupancy), 1);
        ifa.i_redirect = 1'b1;
        ifa.i_halt = 1'b1;
        ifa.i_redirect_pc = 8'h20;
        #1;
        chk("t6_req_same", int'(ifa.o_imem_req), 0);
        step();
        ifa.i_redirect = 1'b0;
        ifa.i_halt = 1'b0;
        #1;
        chk("t6_occ", int'(ifa.o_occupancy), 0);
        chk("t6_addr", int'(ifa.o_imem_addr), 'h20);
        chk("t6_halted", int'(ifa.o_halted), 1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t6_req[%0d]", i), int'(ifa.o_imem_req), 0);
            chk($sformatf("t6_valid[%0d]", i), int'(ifa.o_dec_valid), 0);
            step();
        end

        // Only reset clears halt.
        do_reset(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
